// File: rtl/taylor_pkg.sv
// Shared constants for the fixed-point Maclaurin cosine block.
// Holds the default widths, FSM state encoding and the reciprocal table
// 1/((2k-1)(2k)) scaled by 65536 for k = 1..MAX_TERMS.
package taylor_pkg;

    localparam int unsigned WIDTH_DEF   = 24;
    localparam int unsigned FRAC_DEF    = 10;
    localparam int unsigned MAX_TERMS   = 6;
    localparam int unsigned RECIP_W     = 16;
    localparam int unsigned RECIP_SHIFT = 16;
    localparam int unsigned SHIFT_W     = 5;
    localparam int unsigned K_W         = 3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SQUARE = 3'd1,
        ST_MUL    = 3'd2,
        ST_SCALE  = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    // Entry i holds RECIP[k] for k = i+1.
    localparam logic [RECIP_W-1:0] RECIP [MAX_TERMS] = '{
        16'd32768, 16'd5461, 16'd2185, 16'd1170, 16'd728, 16'd496
    };

endpackage

// File: rtl/taylor_series_fxp_mul.sv
// Signed WIDTH x WIDTH multiply with a run-time arithmetic right shift.
// Ports:
//   a_i, b_i   signed operands
//   shift_i    right-shift amount applied to the full 2*WIDTH product
//   prod_c_o   shifted product wrapped to WIDTH bits (combinational)
module fxp_mul
    import taylor_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic signed [WIDTH-1:0]   a_i,
    input  logic signed [WIDTH-1:0]   b_i,
    input  logic        [SHIFT_W-1:0] shift_i,
    output logic signed [WIDTH-1:0]   prod_c_o
);

    logic signed [2*WIDTH-1:0] prod_full;

    // Full-width product, then floor-shift and wrap.
    assign prod_full = a_i * b_i;
    assign prod_c_o  = WIDTH'(prod_full >>> shift_i);

endmodule

// File: rtl/taylor_series.sv
// Sequential fixed-point cosine: cos(x) = 1 - x^2/2! + x^4/4! - ...
// One multiplier is shared between the square, term-by-x^2 and
// reciprocal-scaling steps; one series term is produced every two cycles.
// Ports:
//   clock      rising-edge clock
//   reset      synchronous active-low reset
//   start      request, only sampled in IDLE
//   angle_in   signed angle in radians, FRAC fractional bits
//   ready_out  one-cycle pulse when cos_out updates
//   cos_out    signed result, held between results
module taylor_series
    import taylor_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned FRAC  = FRAC_DEF,
    parameter int unsigned TERMS = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic signed [WIDTH-1:0] angle_in,
    output logic                    ready_out,
    output logic signed [WIDTH-1:0] cos_out
);

    localparam logic signed [WIDTH-1:0] ONE = WIDTH'(1 << FRAC);

    state_e                  state_q, state_d;
    logic signed [WIDTH-1:0] a_q, a_d;
    logic signed [WIDTH-1:0] x2_q, x2_d;
    logic signed [WIDTH-1:0] term_q, term_d;
    logic signed [WIDTH-1:0] p_q, p_d;
    logic signed [WIDTH-1:0] acc_q, acc_d;
    logic signed [WIDTH-1:0] cos_q, cos_d;
    logic        [K_W-1:0]   k_q, k_d;
    logic                    ready_q, ready_d;

    logic signed [WIDTH-1:0] mul_a_c, mul_b_c, prod_c;
    logic        [SHIFT_W-1:0] shift_c;

    fxp_mul #(.WIDTH(WIDTH)) u_mul (
        .a_i      (mul_a_c),
        .b_i      (mul_b_c),
        .shift_i  (shift_c),
        .prod_c_o (prod_c)
    );

    // Next-state, operand muxing and datapath updates.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        x2_d    = x2_q;
        term_d  = term_q;
        p_d     = p_q;
        acc_d   = acc_q;
        k_d     = k_q;
        cos_d   = cos_q;
        ready_d = 1'b0;
        mul_a_c = a_q;
        mul_b_c = a_q;
        shift_c = SHIFT_W'(FRAC);

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d     = angle_in;
                    k_d     = K_W'(1);
                    state_d = ST_SQUARE;
                end
            end
            ST_SQUARE: begin
                x2_d    = prod_c;
                acc_d   = ONE;
                term_d  = ONE;
                state_d = ST_MUL;
            end
            ST_MUL: begin
                mul_a_c = term_q;
                mul_b_c = x2_q;
                p_d     = prod_c;
                state_d = ST_SCALE;
            end
            ST_SCALE: begin
                mul_a_c = p_q;
                mul_b_c = WIDTH'(RECIP[k_q - K_W'(1)]);
                shift_c = SHIFT_W'(RECIP_SHIFT);
                term_d  = prod_c;
                // Odd-numbered terms carry a minus sign.
                acc_d   = k_q[0] ? (acc_q - prod_c) : (acc_q + prod_c);
                if (k_q == K_W'(TERMS)) begin
                    cos_d   = acc_d;
                    ready_d = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    k_d     = k_q + K_W'(1);
                    state_d = ST_MUL;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            x2_q    <= '0;
            term_q  <= '0;
            p_q     <= '0;
            acc_q   <= '0;
            k_q     <= '0;
            cos_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            x2_q    <= x2_d;
            term_q  <= term_d;
            p_q     <= p_d;
            acc_q   <= acc_d;
            k_q     <= k_d;
            cos_q   <= cos_d;
            ready_q <= ready_d;
        end
    end

    assign ready_out = ready_q;
    assign cos_out   = cos_q;

endmodule

// File: tb/tb_taylor_series.sv
// Directed bench for taylor_series with default parameters.
module tb_taylor_series;

    localparam int W      = 24;
    localparam int LAT    = 9;
    localparam int PERIOD = 11;

    logic                clock = 1'b0;
    logic                reset = 1'b0;
    logic                start = 1'b0;
    logic signed [W-1:0] angle_in = '0;
    logic                ready_out;
    logic signed [W-1:0] cos_out;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int    angle;
        int    exp_cos;
        string name;
    } vec_t;

    vec_t vecs [6];

    taylor_series dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .angle_in  (angle_in),
        .ready_out (ready_out),
        .cos_out   (cos_out)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL global timeout");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One start pulse; optionally change angle_in right after it is sampled.
    task automatic run_one(input int ang, input int exp, input string name,
                           input bit chg, input int chg_ang);
        bit early;
        @(negedge clock);
        angle_in = W'(ang);
        start    = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        if (chg) angle_in = W'(chg_ang);
        early = 1'b0;
        for (int i = 1; i <= LAT; i++) begin
            @(posedge clock);
            #1;
            if (i < LAT && ready_out) early = 1'b1;
        end
        check({name, " early ready"}, int'(early), 0);
        check({name, " ready"}, int'(ready_out), 1);
        check({name, " cos"}, int'(cos_out), exp);
        @(posedge clock);
        #1;
        check({name, " pulse width"}, int'(ready_out), 0);
        check({name, " cos held"}, int'(cos_out), exp);
    endtask

    initial begin
        int   ang;
        int   cnt;
        int   prev;
        bit   seen;
        bit   unstable;
        bit   any_ready;
        real  ideal;
        real  diff;

        vecs[0] = '{0,     1024, "zero"};
        vecs[1] = '{102,   1019, "0.1"};
        vecs[2] = '{1024,  553,  "1.0"};
        vecs[3] = '{1536,  71,   "1.5"};
        vecs[4] = '{-1024, 553,  "-1.0"};
        vecs[5] = '{-1536, 71,   "-1.5"};

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        check("reset ready", int'(ready_out), 0);
        check("reset cos", int'(cos_out), 0);
        @(negedge clock);
        reset = 1'b1;

        // Table-driven single results
        foreach (vecs[i]) run_one(vecs[i].angle, vecs[i].exp_cos, vecs[i].name, 1'b0, 0);

        // start held high: sweep angle by 102 per result
        @(negedge clock);
        ang      = 0;
        angle_in = W'(ang);
        start    = 1'b1;
        prev     = 0;
        for (int n = 0; n < 16; n++) begin
            cnt      = 0;
            seen     = 1'b0;
            unstable = 1'b0;
            while (!seen && cnt < 20) begin
                @(posedge clock);
                #1;
                cnt++;
                if (ready_out) seen = 1'b1;
                else if (n > 0 && int'(cos_out) != prev) unstable = 1'b1;
            end
            if (!seen) begin
                check("sweep timeout", 0, 1);
                break;
            end
            check($sformatf("sweep period n=%0d", n), cnt, (n == 0) ? LAT + 1 : PERIOD);
            if (n > 0) check($sformatf("sweep stable n=%0d", n), int'(unstable), 0);
            ideal = 1024.0 * $cos(real'(ang) / 1024.0);
            diff  = real'(int'(cos_out)) - ideal;
            checks++;
            if (diff > 3.0 || diff < -3.0) begin
                errors++;
                $display("FAIL sweep cos angle=%0d: got %0d expected %0f +-3",
                         ang, int'(cos_out), ideal);
            end
            prev = int'(cos_out);
            ang += 102;
            angle_in = W'(ang);
            if (n == 15) start = 1'b0;
        end
        repeat (3) @(posedge clock);

        // Reset four cycles after start aborts the run
        @(negedge clock);
        angle_in = W'(1024);
        start    = 1'b1;
        @(posedge clock);
        #1;
        start     = 1'b0;
        any_ready = 1'b0;
        repeat (3) begin
            @(posedge clock);
            #1;
            if (ready_out) any_ready = 1'b1;
        end
        @(negedge clock);
        reset = 1'b0;
        repeat (2) begin
            @(posedge clock);
            #1;
            if (ready_out) any_ready = 1'b1;
        end
        check("abort cos cleared", int'(cos_out), 0);
        @(negedge clock);
        reset = 1'b1;
        repeat (12) begin
            @(posedge clock);
            #1;
            if (ready_out) any_ready = 1'b1;
        end
        check("abort no ready", int'(any_ready), 0);
        check("abort cos held 0", int'(cos_out), 0);
        run_one(1024, 553, "after reset", 1'b0, 0);

        // angle_in change after sampling is ignored
        run_one(1536, 71, "mid change", 1'b1, 0);
        run_one(0, 1024, "mid change rev", 1'b1, 1536);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
